sqrt_reconstruct: RTL and testbench

Sequential inverse of the digit-by-digit square-root unit. It takes a root and remainder pair and rebuilds the radicand as num = root² + rem. The square is formed by the same MSB-first, one-root-bit-per-cycle recurrence the root extractor runs forward. It sits beside the square-root unit as a self-check and encode path, and flags any remainder that is not a legal remainder for the given root.

---
 rtl/sqrt_reconstruct_if.sv | 23 ++
 rtl/sqrt_reconstruct.sv | 97 +++++++++
 tb/tb_sqrt_reconstruct.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sqrt_reconstruct_if.sv
// Request/result bundle for sqrt_reconstruct: operands in, busy/done/result out.
// master = requester side, slave = the reconstruct unit.
interface sqrt_reconstruct_if #(
   parameter int ROOT_W = 8
);
   logic                  start;
   logic [ROOT_W-1:0]     root;
   logic [ROOT_W:0]       rem;
   logic                  busy;
   logic                  done;
   logic [2*ROOT_W-1:0]   num;
   logic                  err;

   modport master (
      output start, root, rem,
      input  busy, done, num, err
   );

   modport slave (
      input  start, root, rem,
      output busy, done, num, err
   );
endinterface

// File: rtl/sqrt_reconstruct.sv
// Rebuilds a radicand from a (root, remainder) pair as root^2 + rem, squaring the
// root MSB-first one bit per cycle; flags remainders that exceed 2*root.
module sqrt_reconstruct #(
   parameter int ROOT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   sqrt_reconstruct_if.slave  bus
);
   localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
   localparam int NUM_W = 2 * ROOT_W;

   typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ROOT_W-1:0]    r_r;
   logic [ROOT_W-1:0]    r_q;
   logic [NUM_W-1:0]     r_s;
   logic [ROOT_W:0]      r_rem_q;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_done;
   logic [NUM_W-1:0]     r_num;
   logic                 r_err;

   logic                 w_b;
   logic [NUM_W-1:0]     w_q_ext;
   logic [NUM_W-1:0]     w_add;
   logic [NUM_W-1:0]     w_s_nxt;
   logic [NUM_W-1:0]     w_num_nxt;
   logic                 w_err_nxt;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (bus.start) w_state_nxt = ITER;
         ITER:    if (r_cnt == '0) w_state_nxt = FINISH;
         FINISH:  w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Step (2q)^2 -> (2q+b)^2 = 4q^2 + b*(4q+1); kept at full radicand width so q^2 never truncates.
   always_comb begin
      w_b       = r_r[ROOT_W-1];
      w_q_ext   = {{ROOT_W{1'b0}}, r_q};
      w_add     = w_b ? ((w_q_ext << 2) + NUM_W'(1)) : '0;
      w_s_nxt   = (r_s << 2) + w_add;
      w_num_nxt = r_s + {{(ROOT_W-1){1'b0}}, r_rem_q};
      w_err_nxt = (r_rem_q > {r_q, 1'b0});
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_r     <= '0;
         r_q     <= '0;
         r_s     <= '0;
         r_rem_q <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_num   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_r     <= bus.root;
                  r_rem_q <= bus.rem;
                  r_q     <= '0;
                  r_s     <= '0;
                  r_cnt   <= CNT_W'(ROOT_W - 1);
               end
            end
            ITER: begin
               r_r <= r_r << 1;
               r_s <= w_s_nxt;
               r_q <= {r_q[ROOT_W-2:0], w_b};
               if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            end
            FINISH: begin
               r_num  <= w_num_nxt;
               r_err  <= w_err_nxt;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (r_state != IDLE);
   assign bus.done = r_done;
   assign bus.num  = r_num;
   assign bus.err  = r_err;
endmodule

// File: tb/tb_sqrt_reconstruct.sv
// Directed-vector bench for sqrt_reconstruct (ROOT_W=8): table of operand pairs,
// hand sequences for busy-ignore, back-to-back, mid-op reset, and a full root sweep.
module tb_sqrt_reconstruct;
   localparam int ROOT_W = 8;

   typedef struct {
      logic [7:0]  root;
      logic [8:0]  rem;
      logic [15:0] num;
      logic        err;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   sqrt_reconstruct_if #(.ROOT_W(ROOT_W)) bus ();

   sqrt_reconstruct #(.ROOT_W(ROOT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Issue one request; returns edges from acceptance until done is seen (bounded).
   task automatic do_op(input logic [7:0] rt, input logic [8:0] rm, output int lat);
      @(negedge clk);
      bus.start = 1'b1;
      bus.root  = rt;
      bus.rem   = rm;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   vec_t vecs[12];
   int   lat;
   int   dones;
   logic [15:0] seen_num;
   logic        seen_err;
   logic [8:0]  rrm;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      bus.start = 1'b0;
      bus.root  = '0;
      bus.rem   = '0;

      vecs[0]  = '{8'd5,   9'd3,   16'd28,    1'b0};
      vecs[1]  = '{8'd0,   9'd0,   16'd0,     1'b0};
      vecs[2]  = '{8'd0,   9'd1,   16'd1,     1'b1};
      vecs[3]  = '{8'd255, 9'd510, 16'd65535, 1'b0};
      vecs[4]  = '{8'd255, 9'd511, 16'd0,     1'b1};
      vecs[5]  = '{8'd16,  9'd32,  16'd288,   1'b0};
      vecs[6]  = '{8'd12,  9'd7,   16'd151,   1'b0};
      vecs[7]  = '{8'd200, 9'd100, 16'd40100, 1'b0};
      vecs[8]  = '{8'd1,   9'd2,   16'd3,     1'b0};
      vecs[9]  = '{8'd1,   9'd3,   16'd4,     1'b1};
      vecs[10] = '{8'd100, 9'd200, 16'd10200, 1'b0};
      vecs[11] = '{8'd100, 9'd201, 16'd10201, 1'b1};

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_num",  bus.num,  0);
      check("reset_err",  bus.err,  0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].root, vecs[i].rem, lat);
         check($sformatf("vec%0d_latency", i), lat, 9);
         check($sformatf("vec%0d_busy_at_done", i), bus.busy, 0);
         check($sformatf("vec%0d_num", i), bus.num, vecs[i].num);
         check($sformatf("vec%0d_err", i), bus.err, vecs[i].err);
         @(posedge clk); #1;
         check($sformatf("vec%0d_done_pulse", i), bus.done, 0);
         check($sformatf("vec%0d_num_hold", i), bus.num, vecs[i].num);
      end

      // start while busy must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.root = 8'd12; bus.rem = 9'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("ign_busy_after_accept", bus.busy, 1);
      dones = 0; seen_num = '0; seen_err = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         bus.start = (c == 4);
         bus.root  = (c == 4) ? 8'd3 : 8'd99;
         bus.rem   = (c == 4) ? 9'd0 : 9'd77;
         @(posedge clk); #1;
         if (bus.done) begin
            dones++;
            seen_num = bus.num;
            seen_err = bus.err;
         end
      end
      bus.start = 1'b0;
      check("ign_done_count", dones, 1);
      check("ign_num", seen_num, 151);
      check("ign_err", seen_err, 0);

      // back-to-back: start raised during the done cycle
      do_op(8'd5, 9'd3, lat);
      check("b2b_first_num", bus.num, 28);
      bus.start = 1'b1; bus.root = 8'd200; bus.rem = 9'd100;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("b2b_accepted_busy", bus.busy, 1);
      lat = 0;
      while (!bus.done && lat < 50) begin
         if (bus.num !== 16'd28) check("b2b_num_held", bus.num, 28);
         @(posedge clk); #1;
         lat++;
      end
      check("b2b_latency", lat, 9);
      check("b2b_num", bus.num, 40100);
      check("b2b_err", bus.err, 0);

      // reset in the middle of an operation
      @(negedge clk);
      bus.start = 1'b1; bus.root = 8'd77; bus.rem = 9'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_reset_busy", bus.busy, 0);
      check("mid_reset_done", bus.done, 0);
      check("mid_reset_num",  bus.num,  0);
      check("mid_reset_err",  bus.err,  0);
      @(negedge clk);
      reset = 1'b0;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      check("mid_reset_no_done", dones, 0);
      do_op(8'd16, 9'd32, lat);
      check("post_reset_latency", lat, 9);
      check("post_reset_num", bus.num, 288);
      check("post_reset_err", bus.err, 0);

      // every root with a random remainder against the arithmetic model
      for (int rt = 0; rt < 256; rt++) begin
         rrm = 9'($urandom_range(0, 511));
         do_op(8'(rt), rrm, lat);
         check($sformatf("sweep_num_r%0d_m%0d", rt, rrm), bus.num,
               32'((rt * rt + int'(rrm)) % 65536));
         check($sformatf("sweep_err_r%0d_m%0d", rt, rrm), bus.err,
               (int'(rrm) > 2 * rt) ? 1 : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
